// File: rtl/gpr_pkg.sv
// Shared constants for the GPR writeback arbiter: widths, FSM state codes and the r0 select.
package gpr_pkg;
  localparam int unsigned GPR_DW = 32;
  localparam int unsigned GPR_AW = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  localparam logic [GPR_AW-1:0] R0 = '0;
endpackage

// File: rtl/wb_hold_buf.sv
// Single-entry holding register for a deferred MDU writeback result.
module wb_hold_buf #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_drain,
  input  logic          i_squash,
  input  logic [AW-1:0] i_wsel,
  input  logic [DW-1:0] i_wdata,
  output logic          o_valid,
  output logic [AW-1:0] o_wsel,
  output logic [DW-1:0] o_wdata
);
  logic          r_valid;
  logic [AW-1:0] r_wsel;
  logic [DW-1:0] r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wsel  <= '0;
      r_wdata <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_wsel  <= i_wsel;
      r_wdata <= i_wdata;
    end else if (i_drain || i_squash) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_wsel  = r_wsel;
  assign o_wdata = r_wdata;
endmodule

// File: rtl/gpr_wb_arbiter.sv
// Arbitrates the GPR write port between the pipeline WB stage (priority) and the MDU,
// deferring one MDU result, squashing stale ones and forcing a one-cycle stall on starvation.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int unsigned DW           = GPR_DW,
  parameter int unsigned AW           = GPR_AW,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_wsel,
  input  logic [DW-1:0] pipe_wdata,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [AW-1:0] mdu_wsel,
  input  logic [DW-1:0] mdu_wdata,
  output logic          pipe_stall,
  output logic          gpr_we,
  output logic [AW-1:0] gpr_wsel,
  output logic [DW-1:0] gpr_wdata
);
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [1:0]    r_state, w_state_d;
  logic [CW-1:0] r_wait, w_wait_d;
  logic          r_gpr_we, w_gpr_we_d;
  logic [AW-1:0] r_gpr_wsel, w_gpr_wsel_d;
  logic [DW-1:0] r_gpr_wdata, w_gpr_wdata_d;
  logic          r_stall, w_stall_d;

  logic          w_buf_valid, w_load, w_drain, w_squash;
  logic [AW-1:0] w_buf_wsel;
  logic [DW-1:0] w_buf_wdata;
  logic          w_live, w_mdu_acc, w_mdu_nz;

  wb_hold_buf #(
    .DW(DW),
    .AW(AW)
  ) u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_drain (w_drain),
    .i_squash(w_squash),
    .i_wsel  (mdu_wsel),
    .i_wdata (mdu_wdata),
    .o_valid (w_buf_valid),
    .o_wsel  (w_buf_wsel),
    .o_wdata (w_buf_wdata)
  );

  always_comb begin
    w_live    = pipe_we && (pipe_wsel != AW'(R0)) && !r_stall;
    w_mdu_acc = mdu_valid && !w_buf_valid;
    // r0 MDU results are accepted but never written or buffered
    w_mdu_nz  = mdu_wsel != AW'(R0);

    w_state_d     = r_state;
    w_wait_d      = r_wait;
    w_gpr_we_d    = 1'b0;
    w_gpr_wsel_d  = r_gpr_wsel;
    w_gpr_wdata_d = r_gpr_wdata;
    w_stall_d     = 1'b0;
    w_load        = 1'b0;
    w_drain       = 1'b0;
    w_squash      = 1'b0;

    case (r_state)
      ST_HOLD: begin
        if (!w_live) begin
          w_gpr_we_d    = 1'b1;
          w_gpr_wsel_d  = w_buf_wsel;
          w_gpr_wdata_d = w_buf_wdata;
          w_drain       = 1'b1;
          w_state_d     = ST_IDLE;
        end else begin
          w_gpr_we_d    = 1'b1;
          w_gpr_wsel_d  = pipe_wsel;
          w_gpr_wdata_d = pipe_wdata;
          w_wait_d      = r_wait + CW'(1);
          if (pipe_wsel == w_buf_wsel) begin
            w_squash  = 1'b1;
            w_state_d = ST_IDLE;
          end else if (r_wait == CW'(STARVE_LIMIT - 1)) begin
            w_stall_d = 1'b1;
            w_state_d = ST_FORCE;
          end
        end
      end
      ST_FORCE: begin
        w_gpr_we_d    = 1'b1;
        w_gpr_wsel_d  = w_buf_wsel;
        w_gpr_wdata_d = w_buf_wdata;
        w_drain       = 1'b1;
        w_state_d     = ST_IDLE;
      end
      default: begin
        if (w_live) begin
          w_gpr_we_d    = 1'b1;
          w_gpr_wsel_d  = pipe_wsel;
          w_gpr_wdata_d = pipe_wdata;
          // Same-register MDU result is older than the pipe write: drop it
          if (w_mdu_acc && w_mdu_nz && (mdu_wsel != pipe_wsel)) begin
            w_load    = 1'b1;
            w_wait_d  = '0;
            w_state_d = ST_HOLD;
          end
        end else if (w_mdu_acc && w_mdu_nz) begin
          w_gpr_we_d    = 1'b1;
          w_gpr_wsel_d  = mdu_wsel;
          w_gpr_wdata_d = mdu_wdata;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_gpr_we    <= 1'b0;
      r_gpr_wsel  <= '0;
      r_gpr_wdata <= '0;
      r_stall     <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_wait      <= w_wait_d;
      r_gpr_we    <= w_gpr_we_d;
      r_gpr_wsel  <= w_gpr_wsel_d;
      r_gpr_wdata <= w_gpr_wdata_d;
      r_stall     <= w_stall_d;
    end
  end

  assign mdu_ready  = !w_buf_valid;
  assign pipe_stall = r_stall;
  assign gpr_we     = r_gpr_we;
  assign gpr_wsel   = r_gpr_wsel;
  assign gpr_wdata  = r_gpr_wdata;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_gpr_wb_arbiter;
  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_we;
  logic [AW-1:0] pipe_wsel;
  logic [DW-1:0] pipe_wdata;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_wsel;
  logic [DW-1:0] mdu_wdata;
  logic          pipe_stall;
  logic          gpr_we;
  logic [AW-1:0] gpr_wsel;
  logic [DW-1:0] gpr_wdata;

  gpr_wb_arbiter #(
    .DW          (DW),
    .AW          (AW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_wsel (pipe_wsel),
    .pipe_wdata(pipe_wdata),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_wsel  (mdu_wsel),
    .mdu_wdata (mdu_wdata),
    .pipe_stall(pipe_stall),
    .gpr_we    (gpr_we),
    .gpr_wsel  (gpr_wsel),
    .gpr_wdata (gpr_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: a list of at most one pending MDU result with its age in pipe-write cycles
  logic [AW-1:0] q_sel[$];
  logic [DW-1:0] q_data[$];
  int            m_age;
  bit            m_stall;
  bit            e_we;
  logic [AW-1:0] e_sel;
  logic [DW-1:0] e_data;

  task automatic model_reset();
    q_sel.delete();
    q_data.delete();
    m_age   = 0;
    m_stall = 0;
    e_we    = 0;
  endtask

  task automatic emit(input logic [AW-1:0] s, input logic [DW-1:0] d);
    e_we   = 1;
    e_sel  = s;
    e_data = d;
  endtask

  task automatic model_step();
    bit live, acc, pend;
    pend = q_sel.size() != 0;
    live = pipe_we && pipe_wsel != 0 && !m_stall;
    acc  = mdu_valid && !pend;
    e_we = 0;
    if (pend && (m_stall || !live)) begin
      emit(q_sel[0], q_data[0]);
      q_sel.delete();
      q_data.delete();
      m_stall = 0;
    end else if (live) begin
      emit(pipe_wsel, pipe_wdata);
      if (pend) begin
        if (pipe_wsel == q_sel[0]) begin
          q_sel.delete();
          q_data.delete();
        end else begin
          if (m_age + 1 >= LIM) m_stall = 1;
          m_age++;
        end
      end else if (acc && mdu_wsel != 0 && mdu_wsel != pipe_wsel) begin
        q_sel.push_back(mdu_wsel);
        q_data.push_back(mdu_wdata);
        m_age = 0;
      end
    end else if (acc && mdu_wsel != 0) begin
      emit(mdu_wsel, mdu_wdata);
    end
  endtask

  // Called at a negedge: drive inputs, advance one clock, compare at the next negedge
  task automatic cycle(input bit pw, input logic [AW-1:0] ps, input logic [DW-1:0] pd,
                       input bit mv, input logic [AW-1:0] ms, input logic [DW-1:0] md);
    pipe_we = pw; pipe_wsel = ps; pipe_wdata = pd;
    mdu_valid = mv; mdu_wsel = ms; mdu_wdata = md;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_eq("gpr_we", 32'(gpr_we), 32'(e_we));
    if (e_we) begin
      check_eq("gpr_wsel", 32'(gpr_wsel), 32'(e_sel));
      check_eq("gpr_wdata", gpr_wdata, e_data);
    end
    check_eq("pipe_stall", 32'(pipe_stall), 32'(m_stall));
    check_eq("mdu_ready", 32'(mdu_ready), 32'(q_sel.size() == 0));
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  int  stall_cnt;
  bit  r4_after_stall;
  bit  prev_stall;
  int  we_cnt;

  initial begin
    rst = 1;
    pipe_we = 0; pipe_wsel = 0; pipe_wdata = 0;
    mdu_valid = 0; mdu_wsel = 0; mdu_wdata = 0;
    model_reset();
    #12;
    check_eq("rst_we", 32'(gpr_we), 0);
    check_eq("rst_wsel", 32'(gpr_wsel), 0);
    check_eq("rst_wdata", gpr_wdata, 0);
    check_eq("rst_stall", 32'(pipe_stall), 0);
    check_eq("rst_ready", 32'(mdu_ready), 1);
    @(negedge clk);
    rst = 0;

    // Pipe-only write, then quiet
    cycle(1, 5, 32'h0000_1234, 0, 0, 0);
    check_eq("t1_wsel", 32'(gpr_wsel), 5);
    check_eq("t1_wdata", gpr_wdata, 32'h0000_1234);
    idle();
    check_eq("t1_we_low", 32'(gpr_we), 0);

    // MDU alone
    cycle(0, 0, 0, 1, 8, 32'hDEAD_BEEF);
    check_eq("t2_wsel", 32'(gpr_wsel), 8);
    check_eq("t2_ready", 32'(mdu_ready), 1);
    idle();

    // Same-cycle pipe + MDU, MDU deferred one cycle
    cycle(1, 3, 32'h11, 1, 4, 32'h22);
    check_eq("t3_c1_wsel", 32'(gpr_wsel), 3);
    check_eq("t3_c1_ready", 32'(mdu_ready), 0);
    idle();
    check_eq("t3_c2_wsel", 32'(gpr_wsel), 4);
    check_eq("t3_c2_wdata", gpr_wdata, 32'h22);
    check_eq("t3_c2_ready", 32'(mdu_ready), 1);
    idle();

    // Starvation: pipe hammers R9 while R4 is buffered
    stall_cnt = 0; r4_after_stall = 0; prev_stall = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1, 9, 32'h900 + i, (i == 0), 4, 32'h44);
      if (prev_stall && gpr_we && gpr_wsel == 4) r4_after_stall = 1;
      if (pipe_stall) stall_cnt++;
      prev_stall = pipe_stall;
    end
    check_eq("t4_stall_cycles", stall_cnt, 1);
    check_eq("t4_r4_after_stall", 32'(r4_after_stall), 1);
    idle();

    // WAW squash of a buffered R7
    cycle(1, 2, 32'h1, 1, 7, 32'hAA);
    cycle(1, 7, 32'hBB, 0, 0, 0);
    check_eq("t5_wdata", gpr_wdata, 32'hBB);
    check_eq("t5_ready", 32'(mdu_ready), 1);
    idle();
    check_eq("t5_no_aa", 32'(gpr_we), 0);

    // r0 writes from both sources never reach the GPR
    we_cnt = 0;
    cycle(1, 0, 32'h5, 0, 0, 0);
    we_cnt += int'(gpr_we);
    cycle(0, 0, 0, 1, 0, 32'h6);
    we_cnt += int'(gpr_we);
    cycle(1, 0, 32'h7, 1, 0, 32'h8);
    we_cnt += int'(gpr_we);
    check_eq("t6_r0_we", we_cnt, 0);

    // Reset in the middle of HOLD
    cycle(1, 3, 32'h33, 1, 4, 32'h44);
    #2 rst = 1;
    #1;
    check_eq("t6_rst_we", 32'(gpr_we), 0);
    check_eq("t6_rst_wdata", gpr_wdata, 0);
    check_eq("t6_rst_ready", 32'(mdu_ready), 1);
    model_reset();
    pipe_we = 0; mdu_valid = 0;
    @(negedge clk);
    rst = 0;
    idle();
    idle();

    // Random traffic on a small register range to provoke collisions and r0
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 1) != 0), AW'($urandom_range(0, 3)), $urandom);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
